sprite_capture: RTL

- Write-side counterpart to the sprite display path. Captures one frame's rectangular window of streamed 12-bit RGB pixels into a WIDTH*HEIGHT frame-buffer BRAM.
- That BRAM is later read back for display at the same window layout: row-major, address = (hcount-x)+(vcount-y)*WIDTH.
- Sits between the pixel source (camera or test pattern) and the write port of a xilinx single-port/true-dual-port RAM.
- Armed by a start pulse; reports busy, done and write count.

---
 rtl/sprite_pkg.sv | 15 +
 rtl/sprite_window_addr.sv | 37 +++
 rtl/sprite_capture.sv | 119 +++++++++++
 3 files changed

// File: rtl/sprite_pkg.sv
// Shared types and widths for the sprite capture/display window path.
package sprite_pkg;

    localparam int HCOUNT_W = 11;
    localparam int VCOUNT_W = 10;
    localparam int RGB_W    = 12;

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        CAPTURE,
        DONE
    } capture_state_t;

endpackage

// File: rtl/sprite_window_addr.sv
// Window hit test and row-major frame-buffer address for a WIDTH x HEIGHT sprite.
module sprite_window_addr
    import sprite_pkg::*;
#(
    parameter int WIDTH  = 256,
    parameter int HEIGHT = 256,
    parameter int ADDR_W = $clog2(WIDTH * HEIGHT)
) (
    input  logic [HCOUNT_W-1:0] hcount,
    input  logic [VCOUNT_W-1:0] vcount,
    input  logic [HCOUNT_W-1:0] x,
    input  logic [VCOUNT_W-1:0] y,
    output logic                in_window,
    output logic [ADDR_W-1:0]   addr
);

    logic [HCOUNT_W:0]   x_end;
    logic [VCOUNT_W:0]   y_end;
    logic [HCOUNT_W-1:0] dh;
    logic [VCOUNT_W-1:0] dv;
    logic                h_hit;
    logic                v_hit;

    // One extra bit so a window hanging off the raster clips instead of wrapping.
    assign x_end = {1'b0, x} + (HCOUNT_W + 1)'(WIDTH);
    assign y_end = {1'b0, y} + (VCOUNT_W + 1)'(HEIGHT);

    assign h_hit = (hcount >= x) && ({1'b0, hcount} < x_end);
    assign v_hit = (vcount >= y) && ({1'b0, vcount} < y_end);

    assign in_window = h_hit && v_hit;

    assign dh   = hcount - x;
    assign dv   = vcount - y;
    assign addr = ADDR_W'(dh) + ADDR_W'(dv) * ADDR_W'(WIDTH);

endmodule

// File: rtl/sprite_capture.sv
// Captures one frame's window of streamed pixels into a WIDTH*HEIGHT frame buffer.
module sprite_capture
    import sprite_pkg::*;
#(
    parameter int WIDTH  = 256,
    parameter int HEIGHT = 256,
    parameter int ADDR_W = $clog2(WIDTH * HEIGHT)
) (
    input  logic                pixel_clk_in,
    input  logic                rst_in,
    input  logic                start_in,
    input  logic [HCOUNT_W-1:0] x_in,
    input  logic [VCOUNT_W-1:0] y_in,
    input  logic                pixel_valid_in,
    input  logic [HCOUNT_W-1:0] hcount_in,
    input  logic [VCOUNT_W-1:0] vcount_in,
    input  logic [RGB_W-1:0]    pixel_in,
    output logic [ADDR_W-1:0]   addr_out,
    output logic [RGB_W-1:0]    data_out,
    output logic                we_out,
    output logic                busy_out,
    output logic                done_out,
    output logic [ADDR_W:0]     count_out
);

    localparam logic [ADDR_W:0]   COUNT_MAX = (ADDR_W + 1)'(WIDTH * HEIGHT);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WIDTH * HEIGHT - 1);

    capture_state_t      state;
    capture_state_t      state_d;
    logic [HCOUNT_W-1:0] x;
    logic [VCOUNT_W-1:0] y;
    logic                in_window;
    logic [ADDR_W-1:0]   win_addr;
    logic                frame_start;
    logic                accept;
    logic                wr;
    logic                fin;

    sprite_window_addr #(
        .WIDTH  (WIDTH),
        .HEIGHT (HEIGHT),
        .ADDR_W (ADDR_W)
    ) u_window (
        .hcount    (hcount_in),
        .vcount    (vcount_in),
        .x         (x),
        .y         (y),
        .in_window (in_window),
        .addr      (win_addr)
    );

    assign frame_start = pixel_valid_in && (hcount_in == '0) && (vcount_in == '0);
    assign busy_out    = (state == ARMED) || (state == CAPTURE);

    always_comb begin
        state_d = state;
        accept  = 1'b0;
        wr      = 1'b0;
        fin     = 1'b0;
        unique case (state)
            IDLE, DONE: begin
                if (start_in) begin
                    accept  = 1'b1;
                    state_d = ARMED;
                end
            end
            ARMED: begin
                if (frame_start) begin
                    state_d = CAPTURE;
                    wr      = in_window;
                end
            end
            CAPTURE: begin
                // A recurring frame start means the window was clipped.
                if (frame_start) begin
                    state_d = DONE;
                    fin     = 1'b1;
                end else if (pixel_valid_in && in_window) begin
                    wr = 1'b1;
                end
            end
            default: ;
        endcase
        if (wr && (win_addr == LAST_ADDR)) begin
            state_d = DONE;
            fin     = 1'b1;
        end
    end

    always_ff @(posedge pixel_clk_in) begin
        if (rst_in) begin
            state     <= IDLE;
            x         <= '0;
            y         <= '0;
            addr_out  <= '0;
            data_out  <= '0;
            we_out    <= 1'b0;
            done_out  <= 1'b0;
            count_out <= '0;
        end else begin
            state    <= state_d;
            we_out   <= wr;
            done_out <= fin;
            if (wr) begin
                addr_out <= win_addr;
                data_out <= pixel_in;
            end
            if (accept) begin
                x         <= x_in;
                y         <= y_in;
                count_out <= '0;
            end else if (wr && (count_out != COUNT_MAX)) begin
                count_out <= count_out + 1'b1;
            end
        end
    end

endmodule
